fir_decim_buf: RTL and testbench
================================

# fir_decim_buf

Output stage placed directly downstream of the 5-tap FIR filter. Consumes its 32-bit signed `out_data` stream, keeps every DEC-th sample, rescales it by arithmetic right shift with round-half-up, and clamps it to N bits. Results are buffered in a small first-word-fall-through FIFO with a valid/ready interface toward the sink. Back-pressure is returned to the FIR's sample source through `stop`.

## Interface
- `N`, 16, output sample width (signed)
- `DEC`, 4, decimation factor, ≥1
- `SHIFT`, 3, right-shift applied before narrowing, 0..16
- `DEPTH`, 8, FIFO entries, power of two, ≥4
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; one clock, synchronous active-high reset, named as the codebase does
- `in_valid`  in  1  FIR output sample valid this cycle (driven with the FIR `ready` strobe)
- `in_data`  in  32  signed FIR accumulator sum
- `out_ready`  in  1  sink accepts the head sample
- `out_valid`  out  1  FIFO non-empty
- `out_data`  out  N  signed head sample; 0 when empty
- `stop`  out  1  registered back-pressure to the upstream sample source
- `ovf`  out  1  sticky: a decimated sample was dropped because the FIFO was full
- `sat`  out  1  one-cycle pulse: the sample written this cycle was clamped

## Operation
- Phase counter `ph`, 0..DEC-1, advances on every `in_valid` and wraps DEC-1→0. A sample is accepted only when `in_valid && ph==0`. Other samples are discarded.
- Scaling is done in 33-bit signed arithmetic: `r = in_data + (SHIFT>0 ? 1<<(SHIFT-1) : 0)`, then `r >>> SHIFT`.
- Narrowing clamps to [-2^(N-1), 2^(N-1)-1] (see Configuration).
- Stage register: an accepted sample loads `s_data`, and `s_valid` is set for one cycle.
- FIFO push occurs when `s_valid` is set. Pop occurs on `out_valid && out_ready`. `count` is 0..DEPTH. Pointers wrap modulo DEPTH.
- Push while `count==DEPTH` without a simultaneous pop: sample is dropped, `ovf` is set. `ovf` is cleared only by `rst`.
- Push and pop in the same cycle while full: both are performed, `count` is unchanged, nothing is dropped.
- Push and pop in the same cycle while empty: not possible, since `out_valid` is 0 when empty.
- `stop` is registered: 1 in the cycle after `count ≥ DEPTH-2` and 0 in the cycle after `count < DEPTH-2`. The block keeps accepting input while `stop` is high; drops occur only when the FIFO is truly full.
- Reset values: `ph`=0, pointers=0, `count`=0, `s_valid`=0, `out_valid`=0, `out_data`=0, `stop`=0, `ovf`=0, `sat`=0.
- `rst` mid-operation flushes all queued data on the next edge. FIFO memory contents are don't-care.

## Timing
- Latency from accepted `in_valid` (cycle t) to `out_valid`=1 with that data on `out_data` (cycle t+2):
  - edge ending t: `s_data` loads
  - edge ending t+1: FIFO write
- `sat` pulses in cycle t+1, aligned with the write.
- `out_data` and `out_valid` change only after a clock edge (registered count, FWFT read of the head entry).
- Throughput: one output per DEC `in_valid` strobes. With DEC=1, one sample per clock is sustainable.
- `out_valid` stays high until the pop, and the head value must not change while `out_valid && !out_ready`.

## Configuration
- `FIR_DECIM_SAT_EN` defined: narrowing clamps to the signed N-bit range, and `sat` pulses on each clamp.
- `FIR_DECIM_SAT_EN` undefined: narrowing keeps the low N bits (two's-complement wrap), and `sat` is tied to 0.
- Rounding, decimation and FIFO behaviour are identical in both builds.

## Test plan
All scenarios use defaults (N=16, DEC=4, SHIFT=3, DEPTH=8) and the macro defined unless stated.
- Reset: `rst`=1 for 2 cycles with `in_valid`=1, then release → `out_valid`=0, `out_data`=0, `stop`=0, `ovf`=0. The first accepted sample is the first `in_valid` after release.
- Decimation: `in_valid`=1 continuously, `in_data`=8k for k=0..15, `out_ready`=1 → outputs 0, 4, 8, 12 in order. The first `out_valid` appears 2 cycles after the first accepted strobe.
- Rounding (DEC=1): inputs 12, -12, 11, -13 → outputs 2, -1, 1, -2.
- Saturation:
  - inputs 0x0010_0000 and -1048576 → 32767 and -32768, with `sat` pulsing for each.
  - Same stimulus without `FIR_DECIM_SAT_EN` → 0 and 0, with `sat`=0.
- Back-pressure: `out_ready`=0, 10 accepted samples valued 1..10 → `stop`=1 from the cycle after `count` reaches 6; samples 9 and 10 are dropped; `ovf`=1. Then `out_ready`=1 → exactly 1..8 are drained in order, and `stop` falls once `count` < 6.
- Reset mid-stream: 5 entries queued, `rst` pulsed for 1 cycle → next cycle `out_valid`=0 and `ovf`=0, and the decimation phase restarts at 0.

Source files
------------

// File: rtl/fir_decim_buf.sv
// fir_decim_buf: decimating output stage behind the 5-tap FIR.
// Keeps every DEC-th valid sample. Each kept sample is rescaled by an
// arithmetic right shift with round-half-up, then narrowed to N bits.
// Kept samples are queued in a first-word-fall-through FIFO that has a
// valid/ready interface toward the sink.
// Build option: define FIR_DECIM_SAT_EN to clamp to the signed N-bit range
// and report clamps on `sat`. Leave it undefined to wrap (keep the low N
// bits); in that build `sat` stays 0.
module fir_decim_buf #(
  parameter int N     = 16,
  parameter int DEC   = 4,
  parameter int SHIFT = 3,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic          stop,
  output logic          ovf,
  output logic          sat
);

  localparam int PH_W = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  // Rounding constant: half an LSB of the shifted result, or 0 when no shift.
  localparam logic signed [32:0] RND = (33'sd1 <<< SHIFT) >>> 1;

`ifdef FIR_DECIM_SAT_EN
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (N - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (N - 1));
`endif

  // ---------------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------------
  logic [PH_W-1:0] ph_reg;
  logic            accept;

  assign accept = in_valid && (ph_reg == '0);

  // Advance the phase on every strobe and wrap after DEC strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_reg <= '0;
    end else if (in_valid) begin
      if (ph_reg == PH_W'(DEC - 1)) begin
        ph_reg <= '0;
      end else begin
        ph_reg <= ph_reg + PH_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Rescale: sign-extend to 33 bits so adding the rounding constant to a
  // large positive sum cannot overflow. Then shift arithmetically.
  // ---------------------------------------------------------------------
  logic signed [32:0] ext;
  logic signed [32:0] rounded;
  logic signed [32:0] scaled;
  logic [N-1:0]       narrow;
  logic               sat_now;

  assign ext     = {in_data[31], in_data};
  assign rounded = ext + RND;
  assign scaled  = rounded >>> SHIFT;

  // Narrow to N bits: clamp in the saturating build, wrap otherwise.
  always_comb begin
    narrow  = N'(scaled);
    sat_now = 1'b0;
`ifdef FIR_DECIM_SAT_EN
    if (scaled > MAX_V) begin
      narrow  = MAX_V[N-1:0];
      sat_now = 1'b1;
    end else if (scaled < MIN_V) begin
      narrow  = MIN_V[N-1:0];
      sat_now = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Stage register: holds the narrowed sample for one cycle ahead of the
  // FIFO write. The clamp flag travels with it, so `sat` lines up with
  // the write.
  // ---------------------------------------------------------------------
  logic [N-1:0] s_data_reg;
  logic         s_valid_reg;
  logic         sat_reg;

  // Load the stage on an accepted sample; the valid flag lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_data_reg  <= '0;
      s_valid_reg <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      s_valid_reg <= accept;
      sat_reg     <= accept && sat_now;
      if (accept) begin
        s_data_reg <= narrow;
      end
    end
  end

  assign sat = sat_reg;

  // ---------------------------------------------------------------------
  // FWFT FIFO. The head is read combinationally from registered state, so
  // out_data and out_valid change only after a clock edge.
  // ---------------------------------------------------------------------
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic          ovf_reg;
  logic          stop_reg;

  assign full  = (count_reg == CW'(DEPTH));
  assign push  = s_valid_reg;
  assign pop   = out_valid && out_ready;
  // When the FIFO is full, a push goes ahead only if a pop frees the head
  // slot in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Storage array. It has no reset because its contents are ignored
  // whenever count says the slot is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= s_data_reg;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow flag and registered back-pressure. `stop` asserts with
  // two slots still free, so the samples already in flight can land.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg  <= 1'b0;
      stop_reg <= 1'b0;
    end else begin
      if (drop) begin
        ovf_reg <= 1'b1;
      end
      stop_reg <= (count_reg >= CW'(DEPTH - 2));
    end
  end

  assign ovf       = ovf_reg;
  assign stop      = stop_reg;
  assign out_valid = (count_reg != '0);
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fir_decim_buf.sv
// tb_fir_decim_buf: directed checks of fir_decim_buf.
// Main instance: default parameters (DEC=4).
// Second instance: DEC=1, used for the rounding and one-per-clock cases.
module tb_fir_decim_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        stop;
  logic        ovf;
  logic        sat;

  logic        in_valid1;
  logic [31:0] in_data1;
  logic        out_ready1;
  logic        out_valid1;
  logic [15:0] out_data1;
  logic        stop1;
  logic        ovf1;
  logic        sat1;

  int checks   = 0;
  int failures = 0;
  int q[$];

`ifdef FIR_DECIM_SAT_EN
  localparam int SAT_HI   = 32767;
  localparam int SAT_LO   = -32768;
  localparam int SAT_FLAG = 1;
`else
  localparam int SAT_HI   = 0;
  localparam int SAT_LO   = 0;
  localparam int SAT_FLAG = 0;
`endif

  always #5 clk = ~clk;

  fir_decim_buf #(.N(16), .DEC(4), .SHIFT(3), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .stop(stop), .ovf(ovf), .sat(sat)
  );

  fir_decim_buf #(.N(16), .DEC(1), .SHIFT(3), .DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .stop(stop1), .ovf(ovf1), .sat(sat1)
  );

  // Record every sample popped from the main instance, in pop order.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      q.push_back(int'($signed(out_data)));
    end
  end

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected FIFO occupancy in cycle x of the back-pressure run: sample i
  // is accepted in cycle 4(i-1) and becomes visible two cycles later. The
  // count caps at DEPTH=8.
  function automatic int exp_cnt(input int x);
    int n;
    if (x < 2) return 0;
    n = (x - 2) / 4 + 1;
    return (n > 8) ? 8 : n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals1[4];
    int exp1[4];
    int sat_in[3];
    int sat_out[3];
    int sat_flg[3];
    int x;

    vals1   = '{12, -12, 11, -13};
    exp1    = '{2, -1, 1, -2};
    sat_in  = '{32'h0010_0000, -1048576, 80};
    sat_out = '{SAT_HI, SAT_LO, 10};
    sat_flg = '{SAT_FLAG, SAT_FLAG, 0};

    // Reset held for two cycles while in_valid is high.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd40; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    step(); step();
    rst = 1'b0;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_data", $signed(out_data), 0);
    check_val("rst_stop", int'(stop), 0);
    check_val("rst_ovf", int'(ovf), 0);
    check_val("rst_sat", int'(sat), 0);

    // Decimation: inputs 8k for k=0..15 should give outputs 0, 4, 8, 12.
    q.delete();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(8 * k);
      step();
      if (k == 0) check_val("dec_lat_t1_valid", int'(out_valid), 0);
      if (k == 1) begin
        check_val("dec_lat_t2_valid", int'(out_valid), 1);
        check_val("dec_lat_t2_data", $signed(out_data), 0);
      end
    end
    in_valid = 1'b0;
    repeat (4) step();
    check_val("dec_count", q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++) check_val("dec_data", q[i], 4 * i);

    // Saturation, plus a sample that stays in range. The strobes that
    // should be discarded carry a large value that would clamp if accepted.
    q.delete();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        in_valid = 1'b1;
        in_data  = (j == 0) ? 32'(sat_in[i]) : 32'h7fff_ffff;
        step();
        check_val((j == 0) ? "sat_pulse" : "sat_quiet", int'(sat), (j == 0) ? sat_flg[i] : 0);
      end
    end
    in_valid = 1'b0;
    repeat (4) step();
    check_val("sat_count", q.size(), 3);
    for (int i = 0; i < 3 && i < q.size(); i++) check_val("sat_data", q[i], sat_out[i]);

    // Back-pressure: ten samples valued 1..10 arrive while out_ready=0.
    out_ready = 1'b0;
    q.delete();
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_data  = (c % 4 == 0) ? 32'(8 * (c / 4 + 1)) : 32'd0;
      step();
      x = c + 1;
      check_val("bp_stop", int'(stop), int'(exp_cnt(x - 1) >= 6));
      check_val("bp_ovf", int'(ovf), int'(x >= 34));
      check_val("bp_valid", int'(out_valid), int'(exp_cnt(x) > 0));
      check_val("bp_head", $signed(out_data), (exp_cnt(x) > 0) ? 1 : 0);
    end
    // Drain the queue; stop should fall once the count drops below 6.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      check_val("drain_stop", int'(stop), int'(j <= 3));
      check_val("drain_valid", int'(out_valid), int'(j < 8));
    end
    check_val("drain_ovf_sticky", int'(ovf), 1);
    check_val("drain_count", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) check_val("drain_data", q[i], i + 1);

    // Reset mid-stream: queue five entries and leave the phase at 2.
    out_ready = 1'b0;
    for (int c = 0; c < 18; c++) begin
      in_valid = 1'b1;
      in_data  = (c % 4 == 0) ? 32'(8 * (c / 4 + 1)) : 32'd0;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check_val("mid_pre_valid", int'(out_valid), 1);
    check_val("mid_pre_head", $signed(out_data), 1);
    check_val("mid_pre_ovf", int'(ovf), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_valid", int'(out_valid), 0);
    check_val("mid_rst_data", $signed(out_data), 0);
    check_val("mid_rst_ovf", int'(ovf), 0);
    check_val("mid_rst_stop", int'(stop), 0);
    // The phase must restart at 0, so the first strobe is the one kept.
    out_ready = 1'b1;
    q.delete();
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = (j == 0) ? 32'd56 : 32'(8 * (j + 20));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check_val("mid_phase_count", q.size(), 1);
    if (q.size() > 0) check_val("mid_phase_data", q[0], 7);

    // Rounding on the DEC=1 instance: one input per clock, one output per clock.
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        in_valid1 = 1'b1;
        in_data1  = 32'(vals1[c]);
      end else begin
        in_valid1 = 1'b0;
      end
      step();
      x = c + 1;
      if (x >= 2) begin
        check_val("rnd_valid", int'(out_valid1), 1);
        check_val("rnd_data", $signed(out_data1), exp1[x - 2]);
      end
    end
    step();
    check_val("rnd_empty", int'(out_valid1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
